// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the P5 CPU.
// Walks FETCH/DECODE/EXEC/MEM/WB and drives the datapath select buses plus
// per-state write enables, decoding opcode/func from the latched IR.
// Outputs are combinational from the current state and decoded instruction,
// and are forced to zero while reset is high.
// Optional build macro MULTICYCLE_PERF_CNT_EN adds cycle_cnt/instr_cnt outputs.
module multicycle_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter int unsigned DM_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       dm_ready,
  output logic [2:0] NPCOp,
  output logic [2:0] WDSel,
  output logic [2:0] WRA3Sel,
  output logic [2:0] ALUOp,
  output logic       BSel,
  output logic       EXTOp,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [2:0] state
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Last wait count before MEM is forcibly left.
  localparam logic [3:0] MEM_LAST = 4'(DM_TIMEOUT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] wait_cnt;

  // PC_RESET documents the datapath's PC base only; nothing here consumes it.
  logic unused_pc_reset;
  assign unused_pc_reset = ^PC_RESET;

  // Instruction decode flags.
  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, needs_exec;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_addu    = is_rtype && (func == FN_ADDU);
  assign is_subu    = is_rtype && (func == FN_SUBU);
  assign is_jr      = is_rtype && (func == FN_JR);
  assign is_ori     = (opcode == OP_ORI);
  assign is_lui     = (opcode == OP_LUI);
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_j       = (opcode == OP_J);
  assign is_jal     = (opcode == OP_JAL);
  assign needs_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

  assign state = cur_state;

  // Per-instruction ALU/operand selects, used from EXEC through WB.
  logic [2:0] sel_alu;
  logic       sel_b;
  logic       sel_ext;

  // Derive the ALU operation and operand/extension selects from the decode.
  always_comb begin
    sel_alu = 3'd0;
    sel_b   = 1'b0;
    sel_ext = 1'b0;
    if (is_addu) begin
      sel_alu = 3'd0;
    end else if (is_subu) begin
      sel_alu = 3'd1;
    end else if (is_ori) begin
      sel_alu = 3'd2;
      sel_b   = 1'b1;
    end else if (is_lui) begin
      sel_alu = 3'd3;
      sel_b   = 1'b1;
    end else if (is_lw || is_sw) begin
      sel_alu = 3'd0;
      sel_b   = 1'b1;
      sel_ext = 1'b1;
    end else if (is_beq) begin
      sel_alu = 3'd1;
      sel_ext = 1'b1;
    end else begin
      sel_alu = 3'd0;
    end
  end

  // State register; an asynchronous reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // MEM wait counter: zero outside MEM, so it is clear on every MEM entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if ((cur_state == MEM) && (nxt_state == MEM)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Next-state and output decode; everything is held at zero during reset.
  always_comb begin
    nxt_state = FETCH;
    NPCOp     = 3'd0;
    WDSel     = 3'd0;
    WRA3Sel   = 3'd0;
    ALUOp     = 3'd0;
    BSel      = 1'b0;
    EXTOp     = 1'b0;
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    RFWr      = 1'b0;
    DMWr      = 1'b0;
    if (reset) begin
      nxt_state = FETCH;
    end else begin
      case (cur_state)
        FETCH: begin
          IRWr      = 1'b1;
          PCWr      = 1'b1;
          NPCOp     = 3'd0;
          nxt_state = DECODE;
        end
        DECODE: begin
          if (is_jal) begin
            RFWr      = 1'b1;
            WRA3Sel   = 3'd2;
            WDSel     = 3'd2;
            PCWr      = 1'b1;
            NPCOp     = 3'd2;
            nxt_state = FETCH;
          end else if (is_j) begin
            PCWr      = 1'b1;
            NPCOp     = 3'd2;
            nxt_state = FETCH;
          end else if (is_jr) begin
            PCWr      = 1'b1;
            NPCOp     = 3'd3;
            nxt_state = FETCH;
          end else if (needs_exec) begin
            nxt_state = EXEC;
          end else begin
            // Unknown opcode/func (including sll nop) retires with no writes.
            nxt_state = FETCH;
          end
        end
        EXEC: begin
          ALUOp = sel_alu;
          BSel  = sel_b;
          EXTOp = sel_ext;
          if (is_beq) begin
            PCWr      = zero;
            NPCOp     = 3'd1;
            nxt_state = FETCH;
          end else if (is_lw || is_sw) begin
            nxt_state = MEM;
          end else begin
            nxt_state = WB;
          end
        end
        MEM: begin
          ALUOp = sel_alu;
          BSel  = sel_b;
          EXTOp = sel_ext;
          DMWr  = is_sw;
          if (dm_ready || (wait_cnt == MEM_LAST)) begin
            nxt_state = is_sw ? FETCH : WB;
          end else begin
            nxt_state = MEM;
          end
        end
        WB: begin
          ALUOp     = sel_alu;
          BSel      = sel_b;
          EXTOp     = sel_ext;
          RFWr      = 1'b1;
          WRA3Sel   = is_rtype ? 3'd1 : 3'd0;
          WDSel     = is_lw ? 3'd1 : 3'd0;
          nxt_state = FETCH;
        end
        default: begin
          nxt_state = FETCH;
        end
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  // Free-running cycle counter and retired-instruction counter (FETCH re-entries).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((cur_state != FETCH) && (nxt_state == FETCH)) begin
        instr_cnt <= instr_cnt + 32'd1;
      end else begin
        instr_cnt <= instr_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: one instruction sequence, each cycle
// checked against a hand-computed output vector at the falling edge.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       dm_ready;
  logic [2:0] NPCOp, WDSel, WRA3Sel, ALUOp, state;
  logic       BSel, EXTOp, PCWr, IRWr, RFWr, DMWr;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int vectors;
  int miscompares;

  multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .func     (func),
    .zero     (zero),
    .dm_ready (dm_ready),
    .NPCOp    (NPCOp),
    .WDSel    (WDSel),
    .WRA3Sel  (WRA3Sel),
    .ALUOp    (ALUOp),
    .BSel     (BSel),
    .EXTOp    (EXTOp),
    .PCWr     (PCWr),
    .IRWr     (IRWr),
    .RFWr     (RFWr),
    .DMWr     (DMWr),
    .state    (state)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {state, NPCOp, WDSel, WRA3Sel, ALUOp, BSel, EXTOp, PCWr, IRWr, RFWr, DMWr}
  function automatic logic [20:0] ev(input int st, input int npc, input int wd, input int wra,
                                     input int alu, input int b, input int ext, input int pcw,
                                     input int irw, input int rfw, input int dmw);
    return {3'(st), 3'(npc), 3'(wd), 3'(wra), 3'(alu), 1'(b), 1'(ext),
            1'(pcw), 1'(irw), 1'(rfw), 1'(dmw)};
  endfunction

  function automatic logic [20:0] observed();
    return {state, NPCOp, WDSel, WRA3Sel, ALUOp, BSel, EXTOp, PCWr, IRWr, RFWr, DMWr};
  endfunction

  // Compare the DUT output vector against the expectation after inputs settle.
  task automatic chk(input string tag, input logic [20:0] exp);
    logic [20:0] obs;
    #1;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func   = fn;
  endtask

  logic [20:0] v_fetch, v_decode, v_idle;

  initial begin
    vectors     = 0;
    miscompares = 0;
    v_fetch  = ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    v_decode = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_idle   = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset    = 1'b1;
    opcode   = 6'b000000;
    func     = 6'b000000;
    zero     = 1'b0;
    dm_ready = 1'b1;

    // Reset held across an edge: all enables and selects zero.
    nxt(); nxt();
    chk("reset_hold", v_idle);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk32("reset_cycle_cnt", cycle_cnt, 32'd0);
    chk32("reset_instr_cnt", instr_cnt, 32'd0);
`endif

    // ori $1,$0,0x1234: 0,1,2,4,0
    reset = 1'b0;
    set_ir(6'b001101, 6'b110100);
    chk("ori_fetch", v_fetch);                                nxt();
    chk("ori_decode", v_decode);                              nxt();
    chk("ori_exec", ev(2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));     nxt();
    chk("ori_wb", ev(4, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0));       nxt();

    // lw with dm_ready low for two MEM cycles: 7 cycles total
    set_ir(6'b100011, 6'b000100);
    chk("lw_fetch", v_fetch);                                 nxt();
    chk("lw_decode", v_decode);                               nxt();
    chk("lw_exec", ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));      nxt();
    dm_ready = 1'b0;
    chk("lw_mem0", ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));      nxt();
    chk("lw_mem1", ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));      nxt();
    dm_ready = 1'b1;
    chk("lw_mem2", ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));      nxt();
    chk("lw_wb", ev(4, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0));        nxt();

    // beq taken then beq not taken, 3 cycles each
    set_ir(6'b000100, 6'b000000);
    zero = 1'b1;
    chk("beq_t_fetch", v_fetch);                              nxt();
    chk("beq_t_decode", v_decode);                            nxt();
    chk("beq_t_exec", ev(2, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0));   nxt();
    zero = 1'b0;
    chk("beq_n_fetch", v_fetch);                              nxt();
    chk("beq_n_decode", v_decode);                            nxt();
    chk("beq_n_exec", ev(2, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));   nxt();

    // jal: link write and jump in DECODE
    set_ir(6'b000011, 6'b000000);
    chk("jal_fetch", v_fetch);                                nxt();
    chk("jal_decode", ev(1, 2, 2, 2, 0, 0, 0, 1, 0, 1, 0));   nxt();

    // j
    set_ir(6'b000010, 6'b000000);
    chk("j_fetch", v_fetch);                                  nxt();
    chk("j_decode", ev(1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0));     nxt();

    // jr
    set_ir(6'b000000, 6'b001000);
    chk("jr_fetch", v_fetch);                                 nxt();
    chk("jr_decode", ev(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));    nxt();

    // sll nop and unknown opcode retire from DECODE with no writes
    set_ir(6'b000000, 6'b000000);
    chk("nop_fetch", v_fetch);                                nxt();
    chk("nop_decode", v_decode);                              nxt();
    set_ir(6'b111111, 6'b100001);
    chk("unk_fetch", v_fetch);                                nxt();
    chk("unk_decode", v_decode);                              nxt();

    // addu
    set_ir(6'b000000, 6'b100001);
    chk("addu_fetch", v_fetch);                               nxt();
    chk("addu_decode", v_decode);                             nxt();
    chk("addu_exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));    nxt();
    chk("addu_wb", ev(4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));      nxt();

    // subu (func matches lw opcode value; must decode as R-type)
    set_ir(6'b000000, 6'b100011);
    chk("subu_fetch", v_fetch);                               nxt();
    chk("subu_decode", v_decode);                             nxt();
    chk("subu_exec", ev(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));    nxt();
    chk("subu_wb", ev(4, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));      nxt();

    // lui
    set_ir(6'b001111, 6'b000000);
    chk("lui_fetch", v_fetch);                                nxt();
    chk("lui_decode", v_decode);                              nxt();
    chk("lui_exec", ev(2, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));     nxt();
    chk("lui_wb", ev(4, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0));       nxt();

    // sw with dm_ready stuck low: DMWr for DM_TIMEOUT=4 cycles, then FETCH
    set_ir(6'b101011, 6'b000000);
    dm_ready = 1'b0;
    chk("sw_fetch", v_fetch);                                 nxt();
    chk("sw_decode", v_decode);                               nxt();
    chk("sw_exec", ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));      nxt();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw_mem%0d", i), ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
      nxt();
    end
    chk("sw_timeout_fetch", v_fetch);                         nxt();

    // second sw: reset asserted mid-MEM drops DMWr and state at once
    chk("sw2_decode", v_decode);                              nxt();
    chk("sw2_exec", ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));     nxt();
    chk("sw2_mem0", ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    reset = 1'b1;
    chk("sw2_async_reset", v_idle);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk32("midrst_cycle_cnt", cycle_cnt, 32'd0);
    chk32("midrst_instr_cnt", instr_cnt, 32'd0);
`endif
    nxt();
    chk("reset_after_edge", v_idle);
    reset = 1'b0;
    dm_ready = 1'b1;
    chk("post_reset_fetch", v_fetch);                         nxt();
    chk("post_reset_decode", v_decode);                       nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
